// File: rtl/sd_block_writer_if.sv
// rtl/sd_block_writer_if.sv - host request/status and SRAM-buffer signals of the SD block writer
interface sd_block_writer_if;
  logic        wr_req;
  logic [31:0] block_addr;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  err_code;
  logic [8:0]  din_addr;
  logic [7:0]  din;

  modport master (
    output wr_req, block_addr, din,
    input  busy, done, error, err_code, din_addr
  );

  modport slave (
    input  wr_req, block_addr, din,
    output busy, done, error, err_code, din_addr
  );
endinterface

// File: rtl/sd_block_writer.sv
// rtl/sd_block_writer.sv - SPI-mode CMD24 single-block writer: command, 512 data bytes from SRAM,
// data-response check and busy wait, finishing with a done/error report.
module sd_block_writer #(
  parameter int CLK_DIV      = 2,
  parameter int R1_TIMEOUT   = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  sd_block_writer_if.slave bus,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_GAP, S_TOKEN, S_DATA, S_CRC, S_RESP, S_BUSYW, S_TAIL, S_END
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t      state, state_n;
  logic [9:0]  byte_cnt, byte_cnt_n;
  logic [15:0] poll_cnt, poll_cnt_n, poll_inc;
  logic [2:0]  err_code, err_n;
  logic        error_q, error_n;
  logic [8:0]  din_addr, addr_n;
  logic        cs_q, cs_n;
  logic [31:0] blk_addr, blk_n;

  logic [7:0]    tx_sr, rx_sr, tx_next;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic          active, load, edge_tick, byte_end;

  assign edge_tick = (div_cnt == DW'(CLK_DIV - 1));
  assign byte_end  = active && edge_tick && sclk && (bit_cnt == 3'd7);
  assign poll_inc  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

  assign cs           = cs_q;
  assign bus.busy     = (state != S_IDLE) && (state != S_END);
  assign bus.done     = (state == S_END);
  assign bus.error    = error_q;
  assign bus.err_code = err_code;
  assign bus.din_addr = din_addr;

  // Byte engine: a load restarts the byte immediately, so back-to-back bytes have no gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sr   <= 8'hFF;
      rx_sr   <= 8'hFF;
      bit_cnt <= 3'd0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b1;
      active  <= 1'b0;
    end else if (load) begin
      tx_sr   <= tx_next;
      mosi    <= tx_next[7];
      bit_cnt <= 3'd0;
      div_cnt <= '0;
      sclk    <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (edge_tick) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk  <= 1'b1;
          rx_sr <= {rx_sr[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            mosi   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {tx_sr[6:0], 1'b0};
            mosi    <= tx_sr[6];
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_cnt <= 10'd0;
      poll_cnt <= 16'd0;
      err_code <= 3'd0;
      error_q  <= 1'b0;
      din_addr <= 9'd0;
      cs_q     <= 1'b1;
      blk_addr <= 32'd0;
    end else begin
      state    <= state_n;
      byte_cnt <= byte_cnt_n;
      poll_cnt <= poll_cnt_n;
      err_code <= err_n;
      error_q  <= error_n;
      din_addr <= addr_n;
      cs_q     <= cs_n;
      blk_addr <= blk_n;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    poll_cnt_n = poll_cnt;
    err_n      = err_code;
    error_n    = error_q;
    addr_n     = din_addr;
    cs_n       = cs_q;
    blk_n      = blk_addr;
    load       = 1'b0;
    tx_next    = 8'hFF;
    case (state)
      S_IDLE: if (bus.wr_req) begin
        blk_n      = bus.block_addr;
        err_n      = 3'd0;
        error_n    = 1'b0;
        cs_n       = 1'b0;
        byte_cnt_n = 10'd0;
        load       = 1'b1;
        tx_next    = 8'h58;
        state_n    = S_CMD;
      end
      S_CMD: if (byte_end) begin
        load = 1'b1;
        if (byte_cnt == 10'd5) begin
          poll_cnt_n = 16'd1;
          state_n    = S_R1;
        end else begin
          byte_cnt_n = byte_cnt + 10'd1;
          case (byte_cnt[2:0])
            3'd0:    tx_next = blk_addr[31:24];
            3'd1:    tx_next = blk_addr[23:16];
            3'd2:    tx_next = blk_addr[15:8];
            3'd3:    tx_next = blk_addr[7:0];
            default: tx_next = 8'hFF;
          endcase
        end
      end
      S_R1: if (byte_end) begin
        load = 1'b1;
        if (rx_sr == 8'h00) begin
          state_n = S_GAP;
        end else if (rx_sr != 8'hFF) begin
          err_n   = 3'd2;
          state_n = S_TAIL;
        end else if (poll_cnt >= 16'(R1_TIMEOUT)) begin
          err_n   = 3'd1;
          state_n = S_TAIL;
        end else begin
          poll_cnt_n = poll_inc;
        end
      end
      S_GAP: if (byte_end) begin
        load    = 1'b1;
        tx_next = 8'hFE;
        addr_n  = 9'd0;
        state_n = S_TOKEN;
      end
      S_TOKEN: if (byte_end) begin
        load       = 1'b1;
        tx_next    = bus.din;
        addr_n     = 9'd1;
        byte_cnt_n = 10'd0;
        state_n    = S_DATA;
      end
      // din_addr runs one byte ahead of the byte on the wire so din has settled by the next load.
      S_DATA: if (byte_end) begin
        load = 1'b1;
        if (byte_cnt == 10'd511) begin
          byte_cnt_n = 10'd0;
          state_n    = S_CRC;
        end else begin
          byte_cnt_n = byte_cnt + 10'd1;
          tx_next    = bus.din;
          addr_n     = (din_addr == 9'd511) ? din_addr : din_addr + 9'd1;
        end
      end
      S_CRC: if (byte_end) begin
        load = 1'b1;
        if (byte_cnt == 10'd1) state_n = S_RESP;
        else                   byte_cnt_n = byte_cnt + 10'd1;
      end
      S_RESP: if (byte_end) begin
        load = 1'b1;
        if (rx_sr[4:0] == 5'h05) begin
          poll_cnt_n = 16'd1;
          state_n    = S_BUSYW;
        end else begin
          err_n   = 3'd3;
          state_n = S_TAIL;
        end
      end
      S_BUSYW: if (byte_end) begin
        load = 1'b1;
        if (rx_sr != 8'h00) begin
          state_n = S_TAIL;
        end else if (poll_cnt >= 16'(BUSY_TIMEOUT)) begin
          err_n   = 3'd4;
          state_n = S_TAIL;
        end else begin
          poll_cnt_n = poll_inc;
        end
      end
      S_TAIL: if (byte_end) begin
        cs_n    = 1'b1;
        error_n = (err_code != 3'd0);
        state_n = S_END;
      end
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// tb/tb_sd_block_writer.sv - scoreboard bench for sd_block_writer with an SPI card model and SRAM model.
module tb_sd_block_writer;
  localparam int CLK_DIV = 1;
  localparam int R1_TO   = 8;
  localparam int BUSY_TO = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cs, sclk, mosi;
  logic miso  = 1'b1;

  sd_block_writer_if bus();

  sd_block_writer #(.CLK_DIV(CLK_DIV), .R1_TIMEOUT(R1_TO), .BUSY_TIMEOUT(BUSY_TO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // SRAM buffer: byte k holds k[7:0], one clk of read latency.
  always @(posedge clk) bus.din <= bus.din_addr[7:0];

  typedef struct { logic [2:0] code; int addr_end; } exp_t;
  exp_t       sb_q[$];
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0, rise_cnt = 0;
  int c_r1_at = 0, c_r1_val = 0, c_resp = 0, c_busy_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Card model: compares every MOSI byte against the expected stream and answers on MISO.
  logic [7:0] rx_b = 8'hFF, out_b = 8'hFF;
  int nbits = 0, cst = 0, ccnt = 0;
  logic sclk_q = 1'b0;
  always @(negedge clk) begin
    if (sclk && !sclk_q) rise_cnt++;
    if (cs !== 1'b0) begin
      nbits = 0; cst = 0; ccnt = 0; out_b = 8'hFF; miso = 1'b1;
    end else if (sclk && !sclk_q) begin
      rx_b = {rx_b[6:0], mosi};
      nbits++;
      if (nbits == 8) begin
        nbits = 0;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mosi_extra: got %02h, required no further byte", rx_b);
        end else begin
          check("mosi_byte", 32'(rx_b), 32'(exp_q.pop_front()));
        end
        case (cst)
          0: begin ccnt++; if (ccnt == 6) begin cst = 1; ccnt = 0; end end
          1: begin ccnt++; if (ccnt == c_r1_at) cst = (c_r1_val == 0) ? 2 : 7; end
          2: if (rx_b == 8'hFE) begin cst = 3; ccnt = 0; end
          3: begin ccnt++; if (ccnt == 512) begin cst = 4; ccnt = 0; end end
          4: begin ccnt++; if (ccnt == 2) cst = 5; end
          5: begin cst = 6; ccnt = 0; end
          6: ccnt++;
          default: ;
        endcase
        case (cst)
          1:       out_b = (ccnt + 1 == c_r1_at) ? 8'(c_r1_val) : 8'hFF;
          5:       out_b = 8'(c_resp);
          6:       out_b = (ccnt < c_busy_n) ? 8'h00 : 8'hFF;
          default: out_b = 8'hFF;
        endcase
      end
    end else if (!sclk && sclk_q) begin
      miso = out_b[7-nbits];
    end
    sclk_q = sclk;
  end

  // Monitor: pops one expectation per done pulse; also watches din_addr stepping.
  logic [8:0] prev_addr = 9'd0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && bus.din_addr != prev_addr)
      check("din_addr_step", 32'(bus.din_addr == 9'd0 || bus.din_addr == prev_addr + 9'd1), 32'd1);
    prev_addr = bus.din_addr;
    if (bus.done) begin
      done_cnt++;
      check("done_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("err_code", 32'(bus.err_code), 32'(e.code));
        check("error", 32'(bus.error), 32'(e.code != 3'd0));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("cs_at_done", 32'(cs), 32'd1);
        check("mosi_bytes_left", 32'(exp_q.size()), 32'd0);
        if (e.addr_end >= 0) check("din_addr_end", 32'(bus.din_addr), 32'(e.addr_end));
      end
    end
  end

  task automatic idle_checks(input string tag);
    check({tag, "_cs"}, 32'(cs), 32'd1);
    check({tag, "_sclk"}, 32'(sclk), 32'd0);
    check({tag, "_mosi"}, 32'(mosi), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
    check({tag, "_din_addr"}, 32'(bus.din_addr), 32'd0);
  endtask

  task automatic run_write(input logic [31:0] addr, input int r1_at, input int r1_val,
                           input int resp, input int busy_n, input int r1_polls,
                           input int has_data, input int busy_polls, input logic [2:0] code,
                           input int extra_req_at, input int abort_at);
    exp_t e;
    int d0, rises;
    c_r1_at = r1_at; c_r1_val = r1_val; c_resp = resp; c_busy_n = busy_n;
    exp_q.push_back(8'h58);
    exp_q.push_back(addr[31:24]);
    exp_q.push_back(addr[23:16]);
    exp_q.push_back(addr[15:8]);
    exp_q.push_back(addr[7:0]);
    exp_q.push_back(8'hFF);
    repeat (r1_polls) exp_q.push_back(8'hFF);
    if (has_data != 0) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFE);
      for (int k = 0; k < 512; k++) exp_q.push_back(8'(k));
      repeat (3) exp_q.push_back(8'hFF);
      repeat (busy_polls) exp_q.push_back(8'hFF);
    end
    exp_q.push_back(8'hFF);
    if (abort_at == 0) begin
      e.code = code;
      e.addr_end = (has_data != 0) ? 511 : -1;
      sb_q.push_back(e);
    end
    d0 = done_cnt;
    @(negedge clk);
    bus.wr_req = 1'b1;
    bus.block_addr = addr;
    @(negedge clk);
    bus.wr_req = 1'b0;
    for (int i = 0; i < 12000 && done_cnt == d0; i++) begin
      if (i == extra_req_at) begin
        bus.wr_req = 1'b1;
        bus.block_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.wr_req = 1'b0;
      end
      if (abort_at != 0 && i == abort_at) begin
        check("cs_low_before_reset", 32'(cs), 32'd0);
        reset = 1'b1;
        #1;
        check("cs_on_reset", 32'(cs), 32'd1);
        exp_q.delete();
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        idle_checks("after_reset");
        rises = rise_cnt;
        d0 = done_cnt;
        repeat (64) @(negedge clk);
        check("sclk_quiet", 32'(rise_cnt - rises), 32'd0);
        check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);
        check("cs_idle_after_reset", 32'(cs), 32'd1);
        return;
      end
      @(negedge clk);
    end
    check("done_in_time", 32'(done_cnt - d0), 32'd1);
    repeat (40) @(negedge clk);
    check("single_done", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    bus.wr_req = 1'b0;
    bus.block_addr = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    idle_checks("reset");
    check("reset_error", 32'(bus.error), 32'd0);
    // Nominal: R1 on 2nd poll, response E5, three busy bytes then release.
    run_write(32'h0000_2000, 2, 8'h00, 8'hE5, 3, 2, 1, 4, 3'd0, -1, 0);
    // MISO stuck high: R1 timeout after 8 polls.
    run_write(32'h1234_5678, 0, 8'h00, 8'hE5, 0, 8, 0, 0, 3'd1, -1, 0);
    check("error_held", 32'(bus.error), 32'd1);
    check("err_code_held", 32'(bus.err_code), 32'd1);
    // R1 = 0x04.
    run_write(32'h0000_0007, 1, 8'h04, 8'hE5, 0, 1, 0, 0, 3'd2, -1, 0);
    // Data rejected with 0x0B: no busy polls, single TAIL byte.
    run_write(32'hA5A5_0001, 3, 8'h00, 8'h0B, 0, 3, 1, 0, 3'd3, -1, 0);
    // Busy stuck low: timeout after 4 polls; a wr_req mid-DATA must be ignored.
    run_write(32'h0000_0100, 1, 8'h00, 8'hE5, 100000, 1, 1, 4, 3'd4, 1000, 0);
    // Reset mid-DATA.
    run_write(32'h0000_0042, 1, 8'h00, 8'hE5, 0, 1, 1, 1, 3'd0, -1, 1500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
